// File: rtl/ripple_counter_pkg.sv
// rtl/ripple_counter_pkg.sv - shared FSM state type and default parameters for the ripple count sampler
package ripple_counter_pkg;

    localparam int DEF_RC_WIDTH    = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MAX_RETRY   = 4;
    localparam int DEF_WRAP_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/ripple_count_sampler_if.sv
// rtl/ripple_count_sampler_if.sv - request/result handshake bundle of the ripple count sampler
interface ripple_count_sampler_if
    import ripple_counter_pkg::*;
#(
    parameter int RC_WIDTH = DEF_RC_WIDTH
) ();

    logic                req_valid;
    logic                req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [RC_WIDTH-1:0] out_count;
    logic                out_at_max;
    logic                out_err;

    modport master (
        output req_valid, out_ready,
        input  req_ready, out_valid, out_count, out_at_max, out_err
    );

    modport slave (
        input  req_valid, out_ready,
        output req_ready, out_valid, out_count, out_at_max, out_err
    );

endinterface

// File: rtl/ff_sync.sv
// rtl/ff_sync.sv - multi-stage flop synchronizer with synchronous active-high clear
module ff_sync
    import ripple_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_RC_WIDTH,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg_q [STAGES];
    logic [WIDTH-1:0] stg_d [STAGES];

    always_comb begin
        stg_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (clr) begin
                stg_q[i] <= '0;
            end else begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - samples an asynchronous ripple counter until two consecutive synchronized reads agree
module ripple_count_sampler
    import ripple_counter_pkg::*;
#(
    parameter int RC_WIDTH    = DEF_RC_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int WRAP_WIDTH  = DEF_WRAP_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [RC_WIDTH-1:0]   count_in,
    input  logic [RC_WIDTH-1:0]   max_count,
    output logic [WRAP_WIDTH-1:0] wrap_cnt,
    ripple_count_sampler_if.slave bus
);

    localparam int RETRY_W = $clog2(MAX_RETRY);

    logic [RC_WIDTH-1:0]   sync_q;
    state_t                state_q,     state_d;
    logic [RC_WIDTH-1:0]   snap_q,      snap_d;
    logic [RETRY_W-1:0]    retry_q,     retry_d;
    logic [RC_WIDTH-1:0]   out_count_q, out_count_d;
    logic                  out_at_max_q, out_at_max_d;
    logic                  out_err_q,   out_err_d;
    logic [RC_WIDTH-1:0]   last_q,      last_d;
    logic [WRAP_WIDTH-1:0] wrap_q,      wrap_d;
    logic                  req_ready_q, req_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [RC_WIDTH-1:0]   max_m1;

    ff_sync #(
        .WIDTH  (RC_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .clr (clr),
        .d   (count_in),
        .q   (sync_q)
    );

    // max_count of 0 wraps to all-ones, matching a counter that rolls over at 2^RC_WIDTH
    assign max_m1 = max_count - RC_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        retry_d      = retry_q;
        out_count_d  = out_count_q;
        out_at_max_d = out_at_max_q;
        out_err_d    = out_err_q;
        last_d       = last_q;
        wrap_d       = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                snap_d  = sync_q;
                retry_d = '0;
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (sync_q == snap_q) begin
                    out_count_d  = snap_q;
                    out_at_max_d = (snap_q == max_m1);
                    out_err_d    = 1'b0;
                    state_d      = ST_HOLD;
                    last_d       = snap_q;
                    if (snap_q < last_q && wrap_q != '1) begin
                        wrap_d = wrap_q + WRAP_WIDTH'(1);
                    end
                end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                    // Give up: report the latest read flagged as unreliable, leave wrap tracking alone
                    out_count_d  = sync_q;
                    out_at_max_d = (sync_q == max_m1);
                    out_err_d    = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    snap_d  = sync_q;
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            retry_q      <= '0;
            out_count_q  <= '0;
            out_at_max_q <= (max_m1 == '0);
            out_err_q    <= 1'b0;
            last_q       <= '0;
            wrap_q       <= '0;
            req_ready_q  <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            retry_q      <= retry_d;
            out_count_q  <= out_count_d;
            out_at_max_q <= out_at_max_d;
            out_err_q    <= out_err_d;
            last_q       <= last_d;
            wrap_q       <= wrap_d;
            req_ready_q  <= req_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_at_max = out_at_max_q;
    assign bus.out_err    = out_err_q;
    assign wrap_cnt       = wrap_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - scoreboard bench for ripple_count_sampler
module tb_ripple_count_sampler;
    import ripple_counter_pkg::*;

    typedef struct {
        int         lat;
        logic       err;
        logic [2:0] count;
        logic       at_max;
        logic [7:0] wrap;
    } exp_t;

    logic       clk;
    logic       clr;
    logic [2:0] count_in;
    logic [2:0] max_count;
    logic [7:0] wrap_cnt;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [2:0] m_last;
    logic [7:0] m_wrap;

    ripple_count_sampler_if #(.RC_WIDTH(3)) ifc ();

    ripple_count_sampler #(
        .RC_WIDTH    (3),
        .SYNC_STAGES (2),
        .MAX_RETRY   (4),
        .WRAP_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .count_in  (count_in),
        .max_count (max_count),
        .wrap_cnt  (wrap_cnt),
        .bus       (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input bit tog);
        @(posedge clk);
        #1;
        if (tog) count_in = count_in + 3'd1;
    endtask

    // mode: 0 = normal release, 1 = clear while holding the result
    task automatic do_sample(input logic [2:0] val, input bit tog, input int bp, input bit clr_hold);
        exp_t       e;
        exp_t       got;
        int         n;
        logic [2:0] mm1;
        logic [2:0] hc;
        logic       he;
        logic       hm;
        count_in = val;
        repeat (4) tick(tog);
        mm1      = max_count - 3'd1;
        e.err    = tog;
        e.lat    = tog ? 6 : 3;
        e.count  = val;
        e.at_max = (val == mm1);
        if (!tog) begin
            if (val < m_last && m_wrap != 8'hff) m_wrap = m_wrap + 8'd1;
            m_last = val;
        end
        e.wrap = m_wrap;
        sb.push_back(e);
        ifc.req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, ifc.req_ready}, 32'd1);
        tick(tog);
        ifc.req_valid = 1'b0;
        n = 1;
        while (!ifc.out_valid && n < 20) begin
            tick(tog);
            n++;
        end
        got = sb.pop_front();
        chk("latency", n, got.lat);
        chk("out_err", {31'd0, ifc.out_err}, {31'd0, got.err});
        if (!got.err) begin
            chk("out_count", {29'd0, ifc.out_count}, {29'd0, got.count});
            chk("out_at_max", {31'd0, ifc.out_at_max}, {31'd0, got.at_max});
        end
        chk("wrap_cnt", {24'd0, wrap_cnt}, {24'd0, got.wrap});
        hc = ifc.out_count;
        he = ifc.out_err;
        hm = ifc.out_at_max;
        for (int i = 0; i < bp; i++) begin
            tick(1'b0);
            chk("bp_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("bp_ready", {31'd0, ifc.req_ready}, 32'd0);
            chk("bp_count", {29'd0, ifc.out_count}, {29'd0, hc});
            chk("bp_err", {31'd0, ifc.out_err}, {31'd0, he});
            chk("bp_at_max", {31'd0, ifc.out_at_max}, {31'd0, hm});
        end
        if (clr_hold) begin
            clr = 1'b1;
            tick(1'b0);
            chk("clr_valid", {31'd0, ifc.out_valid}, 32'd0);
            clr = 1'b0;
            m_last = 3'd0;
            m_wrap = 8'd0;
            tick(1'b0);
            chk("clr_req_ready", {31'd0, ifc.req_ready}, 32'd1);
            chk("clr_wrap", {24'd0, wrap_cnt}, 32'd0);
            chk("clr_count", {29'd0, ifc.out_count}, 32'd0);
        end else begin
            ifc.out_ready = 1'b1;
            tick(1'b0);
            ifc.out_ready = 1'b0;
            chk("release_valid", {31'd0, ifc.out_valid}, 32'd0);
            chk("release_ready", {31'd0, ifc.req_ready}, 32'd1);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        m_last        = 3'd0;
        m_wrap        = 8'd0;
        clr           = 1'b1;
        count_in      = 3'd5;
        max_count     = 3'd4;
        ifc.req_valid = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) tick(1'b0);
        chk("rst_req_ready", {31'd0, ifc.req_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_wrap", {24'd0, wrap_cnt}, 32'd0);
        chk("rst_count", {29'd0, ifc.out_count}, 32'd0);
        chk("rst_err", {31'd0, ifc.out_err}, 32'd0);
        chk("rst_at_max", {31'd0, ifc.out_at_max}, 32'd0);
        clr = 1'b0;
        tick(1'b0);

        do_sample(3'd3, 1'b0, 0, 1'b0);
        do_sample(3'd5, 1'b1, 0, 1'b0);
        do_sample(3'd6, 1'b0, 0, 1'b0);
        do_sample(3'd1, 1'b0, 0, 1'b0);
        do_sample(3'd2, 1'b0, 10, 1'b1);

        max_count = 3'd0;
        do_sample(3'd7, 1'b0, 0, 1'b0);
        max_count = 3'd4;

        for (int k = 0; k < 300; k++) begin
            do_sample(3'd1, 1'b0, 0, 1'b0);
            do_sample(3'd6, 1'b0, 0, 1'b0);
        end
        chk("wrap_saturated", {24'd0, wrap_cnt}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 SHALL have parameter RC_WIDTH, default 3, width of sampled ripple count.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal 2..4).
REQ-003 SHALL have parameter MAX_RETRY, default 4, compare attempts before error (legal >=2).
REQ-004 SHALL have parameter WRAP_WIDTH, default 8, width of wrap counter.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock, all flops on rising edge.
REQ-006 clr  input  1  synchronous active-high reset.
REQ-007 count_in  input  RC_WIDTH  asynchronous ripple counter value.
REQ-008 max_count  input  RC_WIDTH  quasi-static terminal count of the upstream counter.
REQ-009 req_valid  input  1  sample request.
REQ-010 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-011 out_valid  output  1  sample result available.
REQ-012 out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-013 out_count  output  RC_WIDTH  stable sampled count.
REQ-014 out_at_max  output  1  out_count equals (max_count-1) modulo 2^RC_WIDTH.
REQ-015 out_err  output  1  no stable value found within MAX_RETRY compares.
REQ-016 wrap_cnt  output  WRAP_WIDTH  saturating count of detected wrap-arounds.

Function
REQ-017 Each count_in bit SHALL pass through SYNC_STAGES flops continuously (sync_q), independent of FSM state.
REQ-018 FSM states SHALL be IDLE, CAPTURE, COMPARE, HOLD.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake in IDLE moves FSM to CAPTURE.
REQ-020 CAPTURE SHALL load snap <= sync_q, clear retry counter, go to COMPARE.
REQ-021 COMPARE with sync_q == snap SHALL load out_count <= snap, out_err <= 0, go to HOLD.
REQ-022 COMPARE with mismatch SHALL load snap <= sync_q and increment retry; on mismatch at attempt MAX_RETRY it SHALL instead load out_count <= sync_q, out_err <= 1, go to HOLD.
REQ-023 Minimum latency: out_valid high 3 clk after the request-handshake edge; each mismatch adds 1 clk.
REQ-024 out_valid SHALL be 1 exactly in HOLD; out_count, out_at_max, out_err SHALL stay stable while out_valid=1.
REQ-025 HOLD with out_ready=1 SHALL return to IDLE; next request accepted no earlier than the following cycle.
REQ-026 On entry to HOLD, if new out_count < last_count, wrap_cnt SHALL increment, saturating at all-ones; last_count <= new out_count.
REQ-027 Error samples (out_err=1) SHALL NOT update last_count or wrap_cnt.
REQ-028 out_at_max SHALL be registered with out_count; max_count=0 compares against all-ones.

Reset
REQ-029 clr=1 SHALL, at next clk edge, force IDLE, sync flops, snap, retry, last_count, out_count, out_err, wrap_cnt to 0; out_at_max reevaluates from cleared count; reset has priority over all transitions.
REQ-030 clr asserted mid-operation (any state) SHALL drop out_valid next cycle with no handshake completed; req_ready=1 the cycle after clr deasserts.

Structure
REQ-031 Shared package ripple_counter_pkg SHALL hold the FSM state enum and default parameter constants (RC_WIDTH, SYNC_STAGES, MAX_RETRY, WRAP_WIDTH).
REQ-032 Synchronizer SHALL be sub-module ff_sync (parameters WIDTH, STAGES, synchronous active-high clear), instantiated once for the count_in bus.

Verification
REQ-033 Reset: clr=1 two cycles with count_in=5 -> req_ready=1, out_valid=0, wrap_cnt=0, out_count=0.
REQ-034 Stable sample: count_in=3 held, req_valid pulse -> out_valid 3 cycles after handshake, out_count=3, out_err=0; with max_count=4, out_at_max=1.
REQ-035 Toggling input: count_in changes every cycle, MAX_RETRY=4 -> out_err=1 after 4 mismatches, wrap_cnt unchanged.
REQ-036 Wrap: samples 6 then 1 -> wrap_cnt=1; drive 300 wraps with WRAP_WIDTH=8 -> wrap_cnt=255 holds.
REQ-037 Backpressure/reset: out_ready=0 for 10 cycles -> outputs stable, req_ready=0; assert clr in HOLD -> out_valid=0 next cycle, req_ready=1 after clr drops.
